// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer.
// Fetches sequential instruction words from a single-outstanding-request memory
// port into a small FIFO and presents the head entry to the CPU. A redirect
// flushes the FIFO and restarts fetching at redirect_pc; a request that is
// already in flight when the redirect arrives is finished off in DISCARD and
// its data is dropped.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   redirect/_pc        flush and restart fetch at redirect_pc
//   mem_req/_addr       memory request (held stable until mem_ack)
//   mem_ack/_rdata      one-cycle response pulse with instruction word
//   inst_valid/_ready   head-entry handshake towards the CPU
//   inst_data/_pc       head instruction and its address
//   level               number of occupied FIFO entries
module instr_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redirect,
  input  logic [31:0]               redirect_pc,
  output logic                      mem_req,
  output logic [31:0]               mem_addr,
  input  logic                      mem_ack,
  input  logic [31:0]               mem_rdata,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [31:0]               inst_data,
  output logic [31:0]               inst_pc,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] LevelFull = (PtrW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StDiscard} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   level_q, level_d;

  logic [31:0]     buf_pc_q   [DEPTH];
  logic [31:0]     buf_data_q [DEPTH];

  logic push, pop;

  // Next-state: FSM, fetch address and FIFO bookkeeping.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Issue only when a slot is guaranteed for the response.
        if (!redirect && (level_q < LevelFull)) begin
          state_d    = StFetch;
          mem_addr_d = fetch_pc_q;
        end
      end
      StFetch: begin
        if (redirect) begin
          // Request still in flight: keep it up until its ack, then drop it.
          state_d = mem_ack ? StIdle : StDiscard;
        end else if (mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = StIdle;
        end
      end
      StDiscard: begin
        if (mem_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (redirect) fetch_pc_d = redirect_pc;

    // A redirect kills any pop in the same cycle.
    pop = inst_valid && inst_ready && !redirect;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // Storage needs no reset: entries are only visible while level is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]   <= mem_addr_q;
      buf_data_q[wr_ptr_q] <= mem_rdata;
    end
  end

  assign mem_req    = (state_q != StIdle);
  assign mem_addr   = mem_addr_q;
  assign inst_valid = (level_q != '0);
  assign inst_data  = buf_data_q[rd_ptr_q];
  assign inst_pc    = buf_pc_q[rd_ptr_q];
  assign level      = level_q;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: memory responder with programmable wait
// states, a program-order scoreboard of expected instruction addresses and a
// monitor that checks every instruction the CPU side accepts.
module tb_instr_prefetch_buffer;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [2:0]  level;

  instr_prefetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .level       (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Memory contents: every address holds a distinct, address-derived word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Scoreboard: program order from the last restart point (reset or redirect).
  logic [31:0] sb_q[$];
  logic [31:0] gen_pc;

  function automatic void sb_topup();
    while (sb_q.size() < 16) begin
      sb_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endfunction

  function automatic void sb_restart(input logic [31:0] pc);
    sb_q.delete();
    gen_pc = pc;
    sb_topup();
  endfunction

  // Memory responder.
  int          wait_min = 0;
  int          wait_max = 0;
  bit          stray_en = 0;
  bit          force_ack = 0;
  bit          mem_busy = 0;
  int          mem_wait = 0;
  logic [31:0] mem_addr_lat;

  always @(negedge clk) begin
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (rst) begin
      mem_busy = 0;
      if (force_ack) mem_ack = 1'b1;
    end else if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
    end else if (mem_req) begin
      if (!mem_busy) begin
        mem_busy     = 1;
        mem_wait     = $urandom_range(wait_max, wait_min);
        mem_addr_lat = mem_addr;
      end else begin
        check("addr_stable", mem_addr, mem_addr_lat);
      end
      if (mem_wait == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        mem_busy  = 0;
      end else begin
        mem_wait--;
      end
    end else begin
      mem_busy = 0;
      if (stray_en && ($urandom % 20) == 0) mem_ack = 1'b1;
    end
  end

  // Monitor.
  bit prev_redir = 0;
  bit thr_chk = 0;
  int cyc = 0;
  int last_pop = -1;

  always @(negedge clk) begin
    logic [31:0] exp_pc;
    #1;
    cyc++;
    if (rst) begin
      prev_redir = 0;
    end else begin
      check("valid_vs_level", 32'(inst_valid), 32'(level != 3'd0));
      check("level_bound", 32'(level <= 3'(DEPTH)), 32'd1);
      if (prev_redir) check("flush_empty", 32'(inst_valid), 32'd0);
      if (inst_valid && inst_ready && !redirect) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got pc %h expected none", inst_pc);
        end else begin
          exp_pc = sb_q.pop_front();
          sb_topup();
          check("inst_pc", inst_pc, exp_pc);
          check("inst_data", inst_data, mem_word(exp_pc));
        end
        if (thr_chk && last_pop >= 0) check("pop_gap", 32'(cyc - last_pop <= 2), 32'd1);
        last_pop = cyc;
      end
      prev_redir = redirect;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb_restart(RESET_PC);
    step(2);
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    sb_restart(pc);
    @(negedge clk);
    redirect = 1'b0;
  endtask

  task automatic wait_req(input logic lvl, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mem_req !== lvl && n < 50);
    if (mem_req !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, mem_req %b expected %b", name, mem_req, lvl);
    end
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = 1'b0;
    sb_restart(RESET_PC);

    // Reset values.
    step(3);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_mem_addr", mem_addr, RESET_PC);

    // First request right after reset release; then streaming throughput.
    rst        = 1'b0;
    inst_ready = 1'b1;
    thr_chk    = 1;
    last_pop   = -1;
    @(negedge clk);
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", mem_addr, RESET_PC);
    step(40);
    thr_chk = 0;

    // Fill with CPU stalled, then release one entry.
    inst_ready = 1'b0;
    do_reset();
    step(20);
    check("full_level", 32'(level), 32'd4);
    check("full_noreq", 32'(mem_req), 32'd0);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    check("pop_level", 32'(level), 32'd3);
    check("pop_noreq", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("refill_req", 32'(mem_req), 32'd1);
    check("refill_addr", mem_addr, 32'h10);

    // Redirect while a slow request is in flight.
    wait_min = 3;
    wait_max = 3;
    do_reset();
    wait_req(1'b1, "slow_req");
    do_redirect(32'h100);
    check("discard_req", 32'(mem_req), 32'd1);
    check("discard_addr", mem_addr, RESET_PC);
    wait_req(1'b0, "discard_end");
    wait_req(1'b1, "redir_req");
    check("redir_addr", mem_addr, 32'h100);
    wait_min   = 0;
    wait_max   = 0;
    inst_ready = 1'b1;
    step(12);

    // Redirect and pop together with two entries buffered.
    inst_ready = 1'b0;
    do_reset();
    n = 0;
    while (level != 3'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("level_two", 32'(level), 32'd2);
    inst_ready = 1'b1;
    do_redirect(32'h200);
    check("redir_pop_level", 32'(level), 32'd0);
    check("redir_pop_valid", 32'(inst_valid), 32'd0);
    step(12);

    // Address wrap at the top of memory.
    do_redirect(32'hFFFF_FFFC);
    wait_req(1'b1, "wrap_req0");
    check("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    wait_req(1'b0, "wrap_gap");
    wait_req(1'b1, "wrap_req1");
    check("wrap_addr1", mem_addr, 32'h0);
    step(12);

    // Reset in the middle of a request, followed by a stray ack.
    inst_ready = 1'b0;
    wait_min   = 3;
    wait_max   = 3;
    do_reset();
    wait_req(1'b1, "mid_req");
    rst = 1'b1;
    sb_restart(RESET_PC);
    #1;
    check("async_mem_req", 32'(mem_req), 32'd0);
    check("async_valid", 32'(inst_valid), 32'd0);
    check("async_level", 32'(level), 32'd0);
    check("async_addr", mem_addr, RESET_PC);
    @(negedge clk);
    rst       = 1'b0;
    force_ack = 1;
    @(negedge clk);
    force_ack = 0;
    check("stray_level0", 32'(level), 32'd0);
    @(negedge clk);
    check("stray_level1", 32'(level), 32'd0);
    step(8);

    // Randomized traffic.
    wait_min = 0;
    wait_max = 3;
    stray_en = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      inst_ready = (($urandom % 4) != 0);
      if (($urandom % 32) == 0) begin
        redirect    = 1'b1;
        redirect_pc = (($urandom % 4) == 0) ? 32'hFFFF_FFF8 : {$urandom, 2'b00};
        sb_restart(redirect_pc);
      end else begin
        redirect = 1'b0;
      end
    end
    @(negedge clk);
    redirect = 1'b0;
    stray_en = 0;
    step(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
